// File: rtl/imem_loader.sv
// imem_loader: streams instruction words into instruction memory from address 0,
// verifies a trailing checksum beat and holds the CPU in reset until the image is good.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 19,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);
    typedef enum logic [2:0] {IDLE, LOAD, CSUM, DONE, ERR} state_t;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    state_t            state_q;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [ADDR_W:0]   cnt_q;
    logic              in_ready_q, mem_we_q, cpu_reset_q, done_q, error_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              accept, full;
    assign accept = in_valid && in_ready_q;
    assign full   = cnt_q == DEPTH_C;
    assign acc_d  = acc_q + in_data;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (accept && full) begin
                        state_q    <= ERR;
                        error_q    <= 1'b1;
                        in_ready_q <= 1'b0;
                    end else if (accept) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= cnt_q[ADDR_W-1:0];
                        mem_wdata_q <= in_data;
                        acc_q       <= acc_d;
                        cnt_q       <= cnt_q + 1'b1;
                        if (in_last) begin
                            state_q    <= CSUM;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                CSUM: begin
                    // ready drops for the entry cycle, then the checksum beat is taken
                    if (!in_ready_q) begin
                        in_ready_q <= 1'b1;
                    end else if (in_valid) begin
                        in_ready_q  <= 1'b0;
                        state_q     <= (in_data == acc_q) ? DONE : ERR;
                        done_q      <= in_data == acc_q;
                        error_q     <= in_data != acc_q;
                        cpu_reset_q <= in_data != acc_q;
                    end
                end
                default: begin
                    if (start) begin
                        state_q     <= LOAD;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        in_ready_q  <= 1'b1;
                        cpu_reset_q <= 1'b1;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                    end
                end
            endcase
        end
    end
    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = cnt_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed loads; expected writes are queued by the driver and
// matched by an independent monitor on every mem_we pulse.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_last;
    logic [18:0] in_data;
    logic        in_ready, mem_we, cpu_reset, done, error;
    logic [7:0]  mem_addr;
    logic [18:0] mem_wdata;
    logic [8:0]  word_count;

    int vectors = 0;
    int miscompares = 0;
    logic [26:0] exp_q[$];
    logic [7:0]  addr_m;

    imem_loader dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write", mem_addr, mem_wdata);
            end else begin
                logic [26:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    miscompares++;
                    $display("FAIL write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                             mem_addr, mem_wdata, e[26:19], e[18:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        addr_m = 8'd0;
    endtask

    // Called and returns at a negedge; wr=1 means the beat must produce a write.
    task automatic send(input logic [18:0] d, input logic l, input bit wr, input int gap);
        int n;
        in_valid = 1'b0;
        for (int i = 0; i < gap; i++) @(negedge clk);
        in_data = d;
        in_last = l;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            if (wr) begin
                exp_q.push_back({addr_m, d});
                addr_m++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic status(input string tag, input logic d, input logic e, input logic cr, input logic [8:0] wc);
        chk({tag, "_done"}, 32'(done), 32'(d));
        chk({tag, "_error"}, 32'(error), 32'(e));
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(cr));
        chk({tag, "_word_count"}, 32'(word_count), 32'(wc));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; addr_m = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        status("rst", 1'b0, 1'b0, 1'b1, 9'd0);
        reset = 1'b0;

        // beats offered while idle must be ignored
        in_valid = 1'b1; in_data = 19'h12345;
        repeat (4) @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // three-word load, good checksum
        pulse_start();
        chk("start_in_ready", 32'(in_ready), 32'd1);
        send(19'h00001, 1'b0, 1'b1, 0);
        send(19'h00002, 1'b0, 1'b1, 0);
        send(19'h40003, 1'b1, 1'b1, 0);
        chk("last_in_ready_drop", 32'(in_ready), 32'd0);
        chk("last_word_count", 32'(word_count), 32'd3);
        @(negedge clk);
        chk("csum_in_ready", 32'(in_ready), 32'd1);
        send(19'h40006, 1'b0, 1'b0, 0);
        status("good", 1'b1, 1'b0, 1'b0, 9'd3);

        // same image, bad checksum
        pulse_start();
        chk("restart_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("restart_done_clr", 32'(done), 32'd0);
        send(19'h00001, 1'b0, 1'b1, 1);
        send(19'h00002, 1'b0, 1'b1, 0);
        send(19'h40003, 1'b1, 1'b1, 2);
        send(19'h40007, 1'b1, 1'b0, 0);
        status("bad", 1'b0, 1'b1, 1'b1, 9'd3);

        // accumulator wraps modulo 2^19
        pulse_start();
        chk("err_clr", 32'(error), 32'd0);
        send(19'h7FFFF, 1'b0, 1'b1, 0);
        send(19'h00002, 1'b1, 1'b1, 0);
        send(19'h00001, 1'b0, 1'b0, 1);
        status("wrap", 1'b1, 1'b0, 1'b0, 9'd2);

        // overflow: 256 words with random gaps, then one more beat
        pulse_start();
        for (int i = 0; i < 256; i++)
            send(19'((i * 19'h0135B) ^ 19'h2A5A5), 1'b0, 1'b1, int'($urandom_range(0, 2)));
        chk("full_word_count", 32'(word_count), 32'd256);
        send(19'h55555, 1'b0, 1'b0, 0);
        status("ovf", 1'b0, 1'b1, 1'b1, 9'd256);

        // reset after 2 of 5 beats, beat 3 held on the bus
        pulse_start();
        send(19'h00011, 1'b0, 1'b1, 0);
        send(19'h00022, 1'b0, 1'b1, 0);
        in_data = 19'h00033; in_valid = 1'b1; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        status("midrst", 1'b0, 1'b0, 1'b1, 9'd0);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;

        // reload from address 0; a start pulse mid-load is ignored
        pulse_start();
        send(19'h00101, 1'b0, 1'b1, 0);
        send(19'h00202, 1'b0, 1'b1, 0);
        pulse_start_ignored();
        send(19'h00303, 1'b0, 1'b1, 0);
        send(19'h00404, 1'b0, 1'b1, 1);
        send(19'h00505, 1'b1, 1'b1, 0);
        send(19'h00F0F, 1'b0, 1'b0, 0);
        status("reload", 1'b1, 1'b0, 1'b0, 9'd5);

        repeat (3) @(negedge clk);
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    task automatic pulse_start_ignored();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ignored_start_count", 32'(word_count), 32'd2);
    endtask
endmodule
